// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the decode->ALU hazard scoreboard.
// Defaults: 32 architectural registers, loads forwardable one cycle after
// issue, ALU results forwardable immediately.
package pipe_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 2 ** REG_W;
  localparam int LOAD_LAT = 1;
  localparam int ALU_LAT  = 0;

  // Countdown width able to hold the longest latency; never narrower than 1 bit.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  localparam int CW = cnt_width(LOAD_LAT);

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: countdown of cycles until a pending register write
// becomes forwardable. busy is high while the count is nonzero.
module sb_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             set,
  input  logic [CNT_W-1:0] set_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: hold on freeze, a new write overrides the decrement.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (!freeze) begin
      if (set) begin
        cnt_d = set_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking '<='; every scoreboard entry is
    // cleared by reset because a stale count would stall after reset.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/da_hazard_scoreboard.sv
// Decode->ALU hazard scoreboard: tracks in-flight register writes, stalls
// decode on uncovered read-after-write and drives the D->A bubble input.
// Optional statistics (stall_cycles, load_use_events) with HAZARD_STATS_EN.
module da_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = pipe_pkg::NUM_REGS,
  parameter int REG_W    = pipe_pkg::REG_W,
  parameter int LOAD_LAT = pipe_pkg::LOAD_LAT,
  parameter int ALU_LAT  = pipe_pkg::ALU_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [REG_W-1:0] D_srcA,
  input  logic [REG_W-1:0] D_srcB,
  input  logic             D_useA,
  input  logic             D_useB,
  input  logic [REG_W-1:0] D_regDst,
  input  logic             D_RF_wrd,
  input  logic             D_isLoad,
  input  logic             A_flush,
  input  logic             freeze,
  output logic             D_stall,
  output logic             A_bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      load_use_events
`endif
);

  localparam int CNT_W = cnt_width(LOAD_LAT);

  logic [NUM_REGS-1:0] busy;
  logic                src_a_busy;
  logic                src_b_busy;
  logic                hazard;
  logic                issue;
  logic                wr_en;
  logic [CNT_W-1:0]    set_val;

  // r0 is hardwired zero and never pending.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .freeze  (freeze),
      .set     (wr_en & (D_regDst == REG_W'(r))),
      .set_val (set_val),
      .busy    (busy[r])
    );
  end

  // Source read muxes, hazard detection and issue qualification; the counters
  // are looked up before this instruction's own write lands.
  always_comb begin
    src_a_busy = D_useA & (D_srcA != '0) & busy[D_srcA];
    src_b_busy = D_useB & (D_srcB != '0) & busy[D_srcB];
    hazard     = D_valid & (src_a_busy | src_b_busy);
    D_stall    = hazard & ~A_flush;
    A_bubble   = reset | ~D_valid | hazard | A_flush;
    issue      = D_valid & ~hazard & ~A_flush & ~freeze;
    wr_en      = issue & D_RF_wrd & (D_regDst != '0);
    set_val    = D_isLoad ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0]         stall_cycles_q, stall_cycles_d;
  logic [31:0]         load_use_events_q, load_use_events_d;
  logic [NUM_REGS-1:0] is_load_q, is_load_d;
  logic                stall_prev_q, stall_prev_d;
  logic                load_block;

  // Remember which pending writes came from loads and update saturating counters.
  always_comb begin
    is_load_d = is_load_q;
    if (wr_en) begin
      is_load_d[D_regDst] = D_isLoad;
    end
    load_block   = (src_a_busy & is_load_q[D_srcA]) | (src_b_busy & is_load_q[D_srcB]);
    stall_prev_d = D_stall;

    stall_cycles_d = stall_cycles_q;
    if (D_stall && !freeze && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end

    load_use_events_d = load_use_events_q;
    if (D_stall && !stall_prev_q && load_block && load_use_events_q != '1) begin
      load_use_events_d = load_use_events_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q    <= '0;
      load_use_events_q <= '0;
      is_load_q         <= '0;
      stall_prev_q      <= 1'b0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      load_use_events_q <= load_use_events_d;
      is_load_q         <= is_load_d;
      stall_prev_q      <= stall_prev_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_events = load_use_events_q;
`endif

endmodule

// File: tb/tb_da_hazard_scoreboard.sv
// Bench for da_hazard_scoreboard: two instances (LOAD_LAT=1 and LOAD_LAT=2)
// share one stimulus stream; a timestamp model predicts stall/bubble.
// Statistics outputs are checked when HAZARD_STATS_EN is defined.
module tb_da_hazard_scoreboard;
  import pipe_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     d_valid, d_use_a, d_use_b, d_rf_wrd, d_is_load, a_flush, freeze;
  reg_idx_t d_src_a, d_src_b, d_reg_dst;
  logic [1:0] stall_o, bub_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles0, load_use0, stall_cycles1, load_use1;
`endif

  int checks = 0;
  int errors = 0;

  // Model: cycle number (unfrozen edges) at which each register is forwardable.
  int lat_ld[2] = '{1, 2};
  int ready[2][NUM_REGS];
  int now;

  always #5 clk = ~clk;

  da_hazard_scoreboard u_dut0 (
    .clk(clk), .reset(reset), .D_valid(d_valid), .D_srcA(d_src_a), .D_srcB(d_src_b),
    .D_useA(d_use_a), .D_useB(d_use_b), .D_regDst(d_reg_dst), .D_RF_wrd(d_rf_wrd),
    .D_isLoad(d_is_load), .A_flush(a_flush), .freeze(freeze),
    .D_stall(stall_o[0]), .A_bubble(bub_o[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles0), .load_use_events(load_use0)
`endif
  );

  da_hazard_scoreboard #(.LOAD_LAT(2)) u_dut1 (
    .clk(clk), .reset(reset), .D_valid(d_valid), .D_srcA(d_src_a), .D_srcB(d_src_b),
    .D_useA(d_use_a), .D_useB(d_use_b), .D_regDst(d_reg_dst), .D_RF_wrd(d_rf_wrd),
    .D_isLoad(d_is_load), .A_flush(a_flush), .freeze(freeze),
    .D_stall(stall_o[1]), .A_bubble(bub_o[1])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles1), .load_use_events(load_use1)
`endif
  );

  function automatic void model_clear();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NUM_REGS; r++) ready[k][r] = 0;
    now = 0;
  endfunction

  function automatic logic m_hazard(int k);
    logic ha, hb;
    ha = d_use_a && (d_src_a != 0) && (ready[k][d_src_a] > now);
    hb = d_use_b && (d_src_b != 0) && (ready[k][d_src_b] > now);
    return d_valid && (ha || hb);
  endfunction

  function automatic logic exp_stall(int k);
    return !reset && m_hazard(k) && !a_flush;
  endfunction

  function automatic logic exp_bub(int k);
    return reset || !d_valid || m_hazard(k) || a_flush;
  endfunction

  task automatic drive(input logic v, input int sa, input logic ua, input int sb, input logic ub,
                       input int dst, input logic wr, input logic ld, input logic fl, input logic fz);
    d_valid = v; d_src_a = reg_idx_t'(sa); d_use_a = ua; d_src_b = reg_idx_t'(sb); d_use_b = ub;
    d_reg_dst = reg_idx_t'(dst); d_rf_wrd = wr; d_is_load = ld; a_flush = fl; freeze = fz;
    #2;
  endtask

  // Advance one clock, applying the issue rule to the model first.
  task automatic tick();
    logic hz[2];
    for (int k = 0; k < 2; k++) hz[k] = m_hazard(k);
    if (!reset && !freeze) begin
      for (int k = 0; k < 2; k++)
        if (d_valid && !hz[k] && !a_flush && d_rf_wrd && d_reg_dst != 0)
          ready[k][d_reg_dst] = now + 1 + (d_is_load ? lat_ld[k] : 0);
      now++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    drive(1, 3, 1, 4, 1, 5, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0 || bub_o[k] !== 1'b1)
        begin errors++; $display("FAIL reset_hold dut%0d: stall=%b bubble=%b, want 0 1", k, stall_o[k], bub_o[k]); end
    end
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== exp_stall(k) || bub_o[k] !== exp_bub(k))
        begin errors++; $display("FAIL reset_release dut%0d: stall=%b bubble=%b, want %b %b", k, stall_o[k], bub_o[k], exp_stall(k), exp_bub(k)); end
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles0 !== 32'd0) begin errors++; $display("FAIL stats_reset: stall_cycles=%0d want 0", stall_cycles0); end
`endif
    tick();
  endtask

  // Load r3 then read r3: LOAD_LAT stall cycles per instance, then issue.
  task automatic test_load_use();
    int n[2];
    n = '{0, 0};
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0 || bub_o[k] !== 1'b0)
        begin errors++; $display("FAIL load_issue dut%0d: stall=%b bubble=%b, want 0 0", k, stall_o[k], bub_o[k]); end
    end
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (stall_o[k] !== exp_stall(k) || bub_o[k] !== exp_bub(k))
          begin errors++; $display("FAIL load_use c%0d dut%0d: stall=%b bubble=%b, want %b %b", c, k, stall_o[k], bub_o[k], exp_stall(k), exp_bub(k)); end
        if (stall_o[k] === 1'b1) n[k]++;
      end
      if (!m_hazard(0) && !m_hazard(1)) break;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (n[k] != lat_ld[k]) begin errors++; $display("FAIL load_use_len dut%0d: %0d stall cycles, want %0d", k, n[k], lat_ld[k]); end
    end
    tick();
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles0 !== 32'd1 || load_use0 !== 32'd1)
      begin errors++; $display("FAIL stats_load_use: stall_cycles=%0d events=%0d, want 1 1", stall_cycles0, load_use0); end
`endif
  endtask

  // ALU result is forwardable at once: no stall.
  task automatic test_alu_use();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0 || bub_o[k] !== 1'b0)
        begin errors++; $display("FAIL alu_use dut%0d: stall=%b bubble=%b, want 0 0", k, stall_o[k], bub_o[k]); end
    end
    tick();
  endtask

  // Writes to r0 never block; an unused source never blocks.
  task automatic test_r0_and_unused();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0) begin errors++; $display("FAIL r0_read dut%0d: stall=%b want 0", k, stall_o[k]); end
    end
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    drive(1, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0) begin errors++; $display("FAIL unused_src dut%0d: stall=%b want 0", k, stall_o[k]); end
    end
    tick();
  endtask

  // LOAD_LAT=2 instance: 3 freeze cycles inside the stall stretch it to 5.
  task automatic test_freeze();
    int n;
    n = 0;
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, (c >= 1 && c <= 3));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (stall_o[k] !== exp_stall(k) || bub_o[k] !== exp_bub(k))
          begin errors++; $display("FAIL freeze c%0d dut%0d: stall=%b bubble=%b, want %b %b", c, k, stall_o[k], bub_o[k], exp_stall(k), exp_bub(k)); end
      end
      if (stall_o[1] === 1'b1) n++;
      if (!m_hazard(1) && !freeze) break;
      tick();
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL freeze_len dut1: %0d stall cycles, want 5", n); end
    tick();
  endtask

  // Flushed load never marks its destination pending.
  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0 || bub_o[k] !== 1'b1)
        begin errors++; $display("FAIL flush_slot dut%0d: stall=%b bubble=%b, want 0 1", k, stall_o[k], bub_o[k]); end
    end
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0) begin errors++; $display("FAIL flush_reader dut%0d: stall=%b want 0", k, stall_o[k]); end
    end
    tick();
  endtask

  // Asynchronous reset in the middle of a load-use stall.
  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_o[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_stall dut1: stall=%b want 1", stall_o[1]); end
    reset = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0 || bub_o[k] !== 1'b1)
        begin errors++; $display("FAIL mid_reset dut%0d: stall=%b bubble=%b, want 0 1", k, stall_o[k], bub_o[k]); end
    end
    tick();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0 || bub_o[k] !== 1'b0)
        begin errors++; $display("FAIL post_reset dut%0d: stall=%b bubble=%b, want 0 0", k, stall_o[k], bub_o[k]); end
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles0 !== 32'd0) begin errors++; $display("FAIL stats_mid_reset: stall_cycles=%0d want 0", stall_cycles0); end
`endif
    tick();
  endtask

  // Random instruction stream over a small register window.
  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      drive(($urandom_range(3, 0) != 0), $urandom_range(7, 0), $urandom_range(1, 0),
            $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
            $urandom_range(1, 0), $urandom_range(1, 0),
            ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (stall_o[k] !== exp_stall(k) || bub_o[k] !== exp_bub(k))
          begin errors++; $display("FAIL random c%0d dut%0d: stall=%b bubble=%b, want %b %b", c, k, stall_o[k], bub_o[k], exp_stall(k), exp_bub(k)); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_load_use();
    drain();
    test_alu_use();
    drain();
    test_r0_and_unused();
    drain();
    test_freeze();
    drain();
    test_flush();
    drain();
    test_reset_mid_stall();
    drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
